// File: rtl/prbs4_pkg.sv
// Shared definitions for the x^4+x^3+1 PRBS generator/checker family:
// FSM encodings, the polynomial step, and common widths.
package prbs4_pkg;

    localparam int DATA_W = 4;
    localparam int RUN_W  = 4;

    localparam logic [DATA_W-1:0] GEN_SEED = 4'b0001;

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_SYNC = 2'd1,
        ST_LOCK = 2'd2
    } state_t;

    // Right shift with feedback into the MSB; 0000 maps to itself and never occurs in-sequence.
    function automatic logic [DATA_W-1:0] prbs4_next(input logic [DATA_W-1:0] d);
        return {d[3] ^ d[0], d[3:1]};
    endfunction

endpackage

// File: rtl/prbs4_step.sv
// One combinational step of the x^4+x^3+1 sequence.
module prbs4_step
    import prbs4_pkg::*;
(
    input  logic [DATA_W-1:0] cur,
    output logic [DATA_W-1:0] nxt
);

    assign nxt = prbs4_next(cur);

endmodule

// File: rtl/prbs4_checker.sv
// Locks onto the 4-bit PRBS stream, flags mispredicted samples while locked,
// and keeps a saturating, clearable error count.
module prbs4_checker
    import prbs4_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    input  logic              clear_i,
    output logic              lock_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  err_cnt_o
);

    localparam logic [RUN_W-1:0] LOCK_TGT = RUN_W'(LOCK_CNT);
    localparam logic [RUN_W-1:0] LOSS_TGT = RUN_W'(LOSS_CNT);

    state_t            state;
    logic [DATA_W-1:0] pred;
    logic [RUN_W-1:0]  mcnt;
    logic [RUN_W-1:0]  brun;

    logic [DATA_W-1:0] seed_nxt;
    logic [DATA_W-1:0] fly_nxt;
    logic [RUN_W-1:0]  mcnt_inc;
    logic [RUN_W-1:0]  brun_inc;
    logic              match;
    logic              data_zero;
    logic              err_hit;
    logic              cnt_sat;

    prbs4_step u_seed_step (
        .cur (data_i),
        .nxt (seed_nxt)
    );

    prbs4_step u_fly_step (
        .cur (pred),
        .nxt (fly_nxt)
    );

    assign mcnt_inc  = mcnt + 4'd1;
    assign brun_inc  = brun + 4'd1;
    assign match     = (data_i == pred);
    assign data_zero = (data_i == '0);
    assign err_hit   = valid_i && (state == ST_LOCK) && !match;
    assign cnt_sat   = &err_cnt_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_HUNT;
            pred      <= '0;
            mcnt      <= '0;
            brun      <= '0;
            lock_o    <= 1'b0;
            err_o     <= 1'b0;
            err_cnt_o <= '0;
        end else begin
            err_o <= 1'b0;
            if (valid_i) begin
                case (state)
                    ST_HUNT: begin
                        if (!data_zero) begin
                            pred  <= seed_nxt;
                            mcnt  <= '0;
                            state <= ST_SYNC;
                        end
                    end
                    ST_SYNC: begin
                        if (match) begin
                            pred <= fly_nxt;
                            mcnt <= mcnt_inc;
                            if (mcnt_inc == LOCK_TGT) begin
                                state  <= ST_LOCK;
                                lock_o <= 1'b1;
                                brun   <= '0;
                            end
                        end else if (!data_zero) begin
                            pred <= seed_nxt;
                            mcnt <= '0;
                        end else begin
                            state <= ST_HUNT;
                        end
                    end
                    ST_LOCK: begin
                        // Flywheel: received data never reseeds the prediction while locked.
                        pred <= fly_nxt;
                        if (match) begin
                            brun <= '0;
                        end else begin
                            err_o <= 1'b1;
                            brun  <= brun_inc;
                            if (brun_inc == LOSS_TGT) begin
                                state  <= ST_HUNT;
                                lock_o <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state  <= ST_HUNT;
                        lock_o <= 1'b0;
                    end
                endcase
            end
            // Clear is applied last so it overrides a same-cycle increment.
            if (err_hit && !cnt_sat)
                err_cnt_o <= err_cnt_o + 1'b1;
            if (clear_i)
                err_cnt_o <= '0;
        end
    end

endmodule

// File: tb/tb_prbs4_checker.sv
// Self-checking bench: hand-derived vector table, directed corner sequences,
// and randomized traffic against a sequence-index reference model.
module tb_prbs4_checker;

    localparam int LOCK_CNT = 4;
    localparam int LOSS_CNT = 3;
    localparam int CNT_W    = 8;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    localparam int M_HUNT = 0;
    localparam int M_SYNC = 1;
    localparam int M_LOCK = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0]       data = 4'd0;
    logic             valid = 1'b0;
    logic             clear = 1'b0;
    logic             lock;
    logic             err;
    logic [CNT_W-1:0] err_cnt;

    prbs4_checker #(
        .LOCK_CNT (LOCK_CNT),
        .LOSS_CNT (LOSS_CNT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_i    (data),
        .valid_i   (valid),
        .clear_i   (clear),
        .lock_o    (lock),
        .err_o     (err),
        .err_cnt_o (err_cnt)
    );

    always #5 clk = ~clk;

    // The full period of the generator, starting from its reset seed.
    logic [3:0] seq [15] = '{4'b0001, 4'b1000, 4'b1100, 4'b1110, 4'b1111,
                             4'b0111, 4'b1011, 4'b0101, 4'b1010, 4'b1101,
                             4'b0110, 4'b0011, 4'b1001, 4'b0100, 4'b0010};

    int checks = 0;
    int errors = 0;
    int g = 0;

    int m_st, m_pred, m_mcnt, m_brun, m_cnt;
    bit m_err;

    typedef struct {
        logic [3:0] d;
        logic       v;
        logic       c;
        logic       l;
        logic       e;
        int         n;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int pos(input logic [3:0] d);
        for (int i = 0; i < 15; i++)
            if (seq[i] == d) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_st = M_HUNT; m_pred = 0; m_mcnt = 0; m_brun = 0; m_cnt = 0; m_err = 0;
    endtask

    task automatic model_step(input logic [3:0] d, input bit v, input bit c);
        m_err = 0;
        if (v) begin
            if (m_st == M_HUNT) begin
                if (d != 0) begin
                    m_pred = (pos(d) + 1) % 15; m_mcnt = 0; m_st = M_SYNC;
                end
            end else if (m_st == M_SYNC) begin
                if (d == seq[m_pred]) begin
                    m_pred = (m_pred + 1) % 15;
                    m_mcnt++;
                    if (m_mcnt == LOCK_CNT) begin
                        m_st = M_LOCK; m_brun = 0;
                    end
                end else if (d != 0) begin
                    m_pred = (pos(d) + 1) % 15; m_mcnt = 0;
                end else begin
                    m_st = M_HUNT;
                end
            end else begin
                logic [3:0] expv;
                expv = seq[m_pred];
                m_pred = (m_pred + 1) % 15;
                if (d == expv) begin
                    m_brun = 0;
                end else begin
                    m_err = 1;
                    if (m_cnt < CNT_MAX) m_cnt++;
                    m_brun++;
                    if (m_brun == LOSS_CNT) m_st = M_HUNT;
                end
            end
        end
        if (c) m_cnt = 0;
    endtask

    // Apply one cycle of inputs, then compare all outputs with the model.
    task automatic cycle(input logic [3:0] d, input bit v, input bit c);
        data = d; valid = v; clear = c;
        @(posedge clk);
        model_step(d, v, c);
        #1;
        chk("lock_o", int'(lock), int'(m_st == M_LOCK));
        chk("err_o", int'(err), int'(m_err));
        chk("err_cnt_o", int'(err_cnt), m_cnt);
    endtask

    task automatic gen(input bit bad, input bit c);
        logic [3:0] d;
        d = bad ? (seq[g] ^ 4'b0011) : seq[g];
        g = (g + 1) % 15;
        cycle(d, 1'b1, c);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst lock_o", int'(lock), 0);
        chk("rst err_o", int'(err), 0);
        chk("rst err_cnt_o", int'(err_cnt), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        tbl[0] = '{4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[1] = '{4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[2] = '{4'b1100, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[3] = '{4'b1110, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[4] = '{4'b1111, 1'b1, 1'b0, 1'b1, 1'b0, 0};
        tbl[5] = '{4'b0111, 1'b1, 1'b0, 1'b1, 1'b0, 0};
        tbl[6] = '{4'b1010, 1'b1, 1'b0, 1'b1, 1'b1, 1};
        tbl[7] = '{4'b0101, 1'b1, 1'b0, 1'b1, 1'b0, 1};
        tbl[8] = '{4'b1010, 1'b1, 1'b1, 1'b1, 1'b0, 0};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset lock_o", int'(lock), 0);
        chk("reset err_o", int'(err), 0);
        chk("reset err_cnt_o", int'(err_cnt), 0);
        rst_n = 1'b1;

        // Lock from the generator seed, single corrupted sample, clear.
        for (int i = 0; i < 9; i++) begin
            cycle(tbl[i].d, tbl[i].v, tbl[i].c);
            chk("tbl lock", int'(lock), int'(tbl[i].l));
            chk("tbl err", int'(err), int'(tbl[i].e));
            chk("tbl cnt", int'(err_cnt), tbl[i].n);
        end
        g = 9;

        for (int i = 0; i < 100; i++) gen(1'b0, 1'b0);
        chk("clean run cnt", int'(err_cnt), 0);
        chk("clean run lock", int'(lock), 1);

        // Three consecutive errors drop lock; relock needs seed + LOCK_CNT.
        gen(1'b1, 1'b0);
        gen(1'b1, 1'b0);
        chk("lock after 2 bad", int'(lock), 1);
        gen(1'b1, 1'b0);
        chk("lock after 3 bad", int'(lock), 0);
        chk("cnt after 3 bad", int'(err_cnt), 3);
        for (int i = 0; i < 4; i++) gen(1'b0, 1'b0);
        chk("relock early", int'(lock), 0);
        gen(1'b0, 1'b0);
        chk("relock", int'(lock), 1);

        // Idle gaps while locked hold everything.
        for (int i = 0; i < 5; i++) cycle(4'($urandom_range(0, 15)), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) gen(1'b0, 1'b0);
        chk("gap cnt", int'(err_cnt), 3);
        chk("gap lock", int'(lock), 1);

        for (int i = 0; i < 4; i++) begin
            gen(1'b1, 1'b0);
            gen(1'b0, 1'b0);
        end
        chk("pre-reset cnt", int'(err_cnt), 7);
        pulse_reset();

        // Zeros in HUNT are ignored; a valid stream then locks.
        for (int i = 0; i < 6; i++) cycle(4'b0000, 1'b1, 1'b0);
        chk("zeros lock", int'(lock), 0);
        for (int i = 0; i < 5; i++) gen(1'b0, 1'b0);
        chk("post-zero lock", int'(lock), 1);

        // Two bad per three samples keeps lock while the count saturates.
        for (int i = 0; i < 400 && m_cnt < CNT_MAX; i++) begin
            gen(1'b1, 1'b0);
            gen(1'b1, 1'b0);
            gen(1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            gen(1'b1, 1'b0);
            gen(1'b0, 1'b0);
        end
        chk("saturated cnt", int'(err_cnt), CNT_MAX);
        gen(1'b1, 1'b1);
        chk("clear vs inc cnt", int'(err_cnt), 0);
        chk("clear vs inc err", int'(err), 1);

        // Randomized traffic: gaps, clears, corrupt samples, sequence jumps.
        for (int i = 0; i < 3000; i++) begin
            bit v, c;
            int r;
            v = ($urandom_range(0, 9) != 0);
            c = ($urandom_range(0, 63) == 0);
            r = $urandom_range(0, 19);
            if (!v) begin
                cycle(4'($urandom_range(0, 15)), 1'b0, c);
            end else if (r == 0) begin
                g = (g + 1) % 15;
                cycle(4'($urandom_range(0, 15)), 1'b1, c);
            end else begin
                if (r == 1) g = $urandom_range(0, 14);
                gen(1'b0, c);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
